seg7_capture: RTL and testbench

- Receive-side counterpart of the hex-to-7-segment encoding on the remote display pins.
- Samples the two remote digit buses (dpy0 = low nibble, dpy1 = high nibble) and decodes them back to an 8-bit number.
- Emits a decoded value only after the pattern has been stable for a programmable time, and flags illegal patterns.
- Used in the env as a loopback monitor and checker of the displayed number; results are presented to a local consumer through a valid/ready handshake.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_dec.sv | 23 ++
 rtl/seg7_capture.sv | 122 ++++++++++++
 tb/tb_seg7_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment capture monitor.
package seg7_pkg;

   localparam int STABLE_CYCLES_DEFAULT = 4;

   localparam logic [7:0] BLANK = 8'h00;

   // Segment byte for each hex nibble, bit map {m, lt, t, rt, lb, b, rb, dp}.
   localparam logic [7:0] SEG_CODE [16] = '{
      8'h7E, 8'h12, 8'hBC, 8'hB6, 8'hD2, 8'hE6, 8'hEE, 8'h32,
      8'hFE, 8'hF2, 8'hFA, 8'hCE, 8'h6C, 8'h9E, 8'hEC, 8'hE8
   };

   typedef enum logic {SETTLE, LOCKED} state_t;

endpackage

// File: rtl/seg7_dec.sv
// Combinational decode of one segment byte back to its hex nibble.
module seg7_dec
   import seg7_pkg::*;
(
   input  logic [7:0] seg,
   output logic       legal,
   output logic [3:0] nibble,
   output logic       blank
);

   always_comb begin
      legal  = 1'b0;
      nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_CODE[i]) begin
            legal  = 1'b1;
            nibble = 4'(i);
         end
      end
      blank = (seg == BLANK);
   end

endmodule

// File: rtl/seg7_capture.sv
// Loopback monitor: synchronizes the remote digit pins, waits for a stable
// pattern, decodes it and hands the number over a valid/ready interface.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
   parameter int CNT_W         = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  dpy0_in,
   input  logic [7:0]  dpy1_in,
   output logic [7:0]  num_data,
   output logic        num_valid,
   input  logic        num_ready,
   output logic        err_invalid,
   output logic [15:0] err_raw,
   output logic        err_overrun,
   input  logic        err_clr
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [15:0]      sync_reg;
   logic [15:0]      samp_reg;
   logic [15:0]      prev_reg;
   logic [CNT_W-1:0] cnt_reg;
   state_t           state_reg;

   logic [1:0]       dec_legal;
   logic [1:0]       dec_blank;
   logic [3:0]       dec_nib [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dec
         seg7_dec u_dec (
            .seg    (samp_reg[gi*8 +: 8]),
            .legal  (dec_legal[gi]),
            .nibble (dec_nib[gi]),
            .blank  (dec_blank[gi])
         );
      end
   endgenerate

   logic changed;
   logic accept;
   logic capture;
   logic invalid;
   logic consume;

   assign changed = (samp_reg != prev_reg);
   assign accept  = (state_reg == SETTLE) && !changed && (cnt_reg == CNT_LAST);
   assign capture = accept && (&dec_legal);
   // An all-blank display is idle, not an error; a half-blank one is illegal.
   assign invalid = accept && !(&dec_legal) && !(&dec_blank);
   assign consume = num_valid && num_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_reg    <= '0;
         samp_reg    <= '0;
         prev_reg    <= '0;
         cnt_reg     <= '0;
         state_reg   <= SETTLE;
         num_data    <= '0;
         num_valid   <= 1'b0;
         err_invalid <= 1'b0;
         err_raw     <= '0;
         err_overrun <= 1'b0;
      end else begin
         sync_reg <= {dpy1_in, dpy0_in};
         samp_reg <= sync_reg;
         prev_reg <= samp_reg;

         if (capture) begin
            num_data  <= {dec_nib[1], dec_nib[0]};
            num_valid <= 1'b1;
         end else if (consume) begin
            num_valid <= 1'b0;
         end

         // New error events take priority over a simultaneous clear.
         if (capture && num_valid && !num_ready) begin
            err_overrun <= 1'b1;
         end else if (err_clr) begin
            err_overrun <= 1'b0;
         end

         if (invalid) begin
            err_invalid <= 1'b1;
            err_raw     <= samp_reg;
         end else if (err_clr) begin
            err_invalid <= 1'b0;
         end

         case (state_reg)
            SETTLE: begin
               if (changed) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= LOCKED;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
            LOCKED: begin
               if (changed) begin
                  cnt_reg   <= '0;
                  state_reg <= SETTLE;
               end
            end
            default: begin
               cnt_reg   <= '0;
               state_reg <= SETTLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized scoreboard bench for seg7_capture with a pin-history reference model.
module tb_seg7_capture;

   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  dpy0_in = 8'h00;
   logic [7:0]  dpy1_in = 8'h00;
   logic [7:0]  num_data;
   logic        num_valid;
   logic        num_ready = 1'b0;
   logic        err_invalid;
   logic [15:0] err_raw;
   logic        err_overrun;
   logic        err_clr = 1'b0;

   seg7_capture #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .dpy0_in     (dpy0_in),
      .dpy1_in     (dpy1_in),
      .num_data    (num_data),
      .num_valid   (num_valid),
      .num_ready   (num_ready),
      .err_invalid (err_invalid),
      .err_raw     (err_raw),
      .err_overrun (err_overrun),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   logic [7:0] codes [16] = '{
      8'h7E, 8'h12, 8'hBC, 8'hB6, 8'hD2, 8'hE6, 8'hEE, 8'h32,
      8'hFE, 8'hF2, 8'hFA, 8'hCE, 8'h6C, 8'h9E, 8'hEC, 8'hE8
   };

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: pin-sample history and expected outputs.
   logic [7:0]  exp_q [$];
   bit          exp_inv = 1'b0;
   bit          exp_ovr = 1'b0;
   logic [15:0] exp_raw = 16'h0;
   logic [15:0] last_smp = 16'h0;
   int          run = 0;
   int          ecount = 0;
   logic [15:0] sched [int];
   bit          started = 1'b0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecount);
   endfunction

   function automatic int nib_of(input logic [7:0] b);
      for (int i = 0; i < 16; i++) if (b == codes[i]) return i;
      return -1;
   endfunction

   // A value sampled on SC+1 consecutive edges (after a change) is acted on
   // two edges after the last of those samples.
   task automatic model_edge();
      logic [15:0] smp;
      logic [15:0] v;
      int hi, lo;
      bit ev_inv, ev_ovr;
      ecount++;
      if (!resetn) begin
         exp_q.delete();
         exp_inv = 1'b0; exp_ovr = 1'b0; exp_raw = 16'h0;
         last_smp = 16'h0; run = 0;
         sched.delete();
         return;
      end
      smp = {dpy1_in, dpy0_in};
      if (smp == last_smp) run++; else run = 1;
      last_smp = smp;
      if (run == SC + 1) sched[ecount + 2] = smp;
      ev_inv = 1'b0; ev_ovr = 1'b0;
      if (sched.exists(ecount)) begin
         v = sched[ecount];
         sched.delete(ecount);
         hi = nib_of(v[15:8]);
         lo = nib_of(v[7:0]);
         if (v == 16'h0000) begin
         end else if (hi >= 0 && lo >= 0) begin
            if (exp_q.size() > 0) begin
               ev_ovr = 1'b1;
               void'(exp_q.pop_back());
            end
            exp_q.push_back({hi[3:0], lo[3:0]});
         end else begin
            ev_inv = 1'b1;
            exp_raw = v;
         end
      end
      if (ev_inv) exp_inv = 1'b1; else if (err_clr) exp_inv = 1'b0;
      if (ev_ovr) exp_ovr = 1'b1; else if (err_clr) exp_ovr = 1'b0;
   endtask

   task automatic step(input logic [7:0] d1, input logic [7:0] d0, input bit rdy, input bit clr);
      dpy1_in = d1; dpy0_in = d0; num_ready = rdy; err_clr = clr;
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic hold(input logic [7:0] d1, input logic [7:0] d0, input bit rdy, input int n);
      for (int i = 0; i < n; i++) step(d1, d0, rdy, 1'b0);
   endtask

   // Monitor: compares DUT outputs to the model away from the active edge and
   // retires the head capture when the handshake completes.
   always @(negedge clk) begin
      if (started) begin
         chk("num_valid", {31'b0, num_valid}, {31'b0, exp_q.size() > 0});
         if (exp_q.size() > 0) begin
            chk("num_data", {24'b0, num_data}, {24'b0, exp_q[0]});
            if (num_ready && resetn) void'(exp_q.pop_front());
         end
         chk("err_invalid", {31'b0, err_invalid}, {31'b0, exp_inv});
         chk("err_overrun", {31'b0, err_overrun}, {31'b0, exp_ovr});
         chk("err_raw", {16'b0, err_raw}, {16'b0, exp_raw});
      end
   end

   initial begin
      int lat;
      int pulses;
      logic [7:0] r1, r0;
      int len;
      int sel;

      resetn = 1'b0;
      step(8'h00, 8'h00, 1'b0, 1'b0);
      step(8'h00, 8'h00, 1'b0, 1'b0);
      started = 1'b1;
      chk("rst_valid", {31'b0, num_valid}, 32'd0);
      chk("rst_data", {24'b0, num_data}, 32'd0);
      chk("rst_raw", {16'b0, err_raw}, 32'd0);

      // Acceptance latency after reset.
      resetn = 1'b1;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         step(8'hD2, 8'hB6, 1'b0, 1'b0);
         lat++;
         if (num_valid) break;
      end
      chk("latency", lat, SC + 3);
      chk("first_data", {24'b0, num_data}, 32'h43);
      hold(8'hD2, 8'hB6, 1'b0, 3);

      // Unconsumed value replaced by a new capture.
      hold(8'h7E, 8'h7E, 1'b0, 10);
      chk("ovr_set", {31'b0, err_overrun}, 32'd1);
      chk("ovr_data", {24'b0, num_data}, 32'h00);
      step(8'h7E, 8'h7E, 1'b1, 1'b1);
      chk("ovr_clr", {31'b0, err_overrun}, 32'd0);

      // Short glitches never settle, then a held value does.
      for (int i = 0; i < 6; i++) begin
         hold(8'hE8, 8'h12, 1'b1, 2);
         hold(8'hE8, 8'hFE, 1'b1, 2);
      end
      hold(8'hE8, 8'hFE, 1'b1, 10);

      // Illegal pattern with dp set, then blank.
      hold(8'hE8, 8'h13, 1'b1, 10);
      chk("inv_flag", {31'b0, err_invalid}, 32'd1);
      chk("inv_raw", {16'b0, err_raw}, 32'hE813);
      hold(8'h00, 8'h00, 1'b1, 10);

      // Continuous consumption: one pulse per value.
      pulses = 0;
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < 10; i++) begin
            step(codes[v], codes[v], 1'b1, 1'b0);
            if (num_valid) pulses++;
         end
      end
      chk("pulse_count", pulses, 3);
      chk("no_overrun", {31'b0, err_overrun}, 32'd0);

      // Randomized segments of varying hold length.
      for (int s = 0; s < 300; s++) begin
         sel = $urandom_range(0, 9);
         r1 = codes[$urandom_range(0, 15)];
         r0 = codes[$urandom_range(0, 15)];
         if (sel == 7) begin
            r1 = 8'h00; r0 = 8'h00;
         end else if (sel == 8) begin
            r0 = 8'($urandom);
         end else if (sel == 9) begin
            r1 = 8'($urandom); r0 = 8'($urandom);
         end
         len = $urandom_range(1, 9);
         for (int i = 0; i < len; i++)
            step(r1, r0, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      end

      // Reset in the middle of settling discards everything.
      hold(8'h12, 8'h12, 1'b0, 10);
      hold(8'hBC, 8'hBC, 1'b0, 3);
      resetn = 1'b0;
      step(8'hBC, 8'hBC, 1'b0, 1'b0);
      chk("mid_rst_valid", {31'b0, num_valid}, 32'd0);
      chk("mid_rst_data", {24'b0, num_data}, 32'd0);
      chk("mid_rst_inv", {31'b0, err_invalid}, 32'd0);
      chk("mid_rst_ovr", {31'b0, err_overrun}, 32'd0);
      chk("mid_rst_raw", {16'b0, err_raw}, 32'd0);
      resetn = 1'b1;
      hold(8'hBC, 8'hBC, 1'b1, 12);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
